// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with redirect, exception, ERET, HALT and stall handling.
// Also tracks EPC/cause/EXL state, emits a flush pulse and counts retired fetches.
`default_nettype none

module pc_unit #(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_VEC  = 32'h0040_0000,
  parameter logic [PC_W-1:0] EXC_VEC    = 32'h0040_0004,
  parameter int              PC_INC     = 4,
  parameter int              CAUSE_W    = 5,
  parameter int              ADEL_CAUSE = 4,
  parameter int              CNT_W      = 16
) (
  input  logic               PCU_clk,
  input  logic               PCU_rst_n,
  input  logic               PCU_ena,
  input  logic               PCU_stall,
  input  logic               PCU_redir_valid,
  input  logic [PC_W-1:0]    PCU_redir_target,
  input  logic               PCU_exc_req,
  input  logic [CAUSE_W-1:0] PCU_exc_cause,
  input  logic               PCU_eret,
  input  logic               PCU_halt_req,
  input  logic               PCU_resume,
  output logic [PC_W-1:0]    PCU_pc_out,
  output logic [PC_W-1:0]    PCU_epc,
  output logic [CAUSE_W-1:0] PCU_cause,
  output logic               PCU_exl,
  output logic               PCU_flush,
  output logic               PCU_halted,
  output logic [CNT_W-1:0]   PCU_retire_cnt
);

  localparam logic [PC_W-1:0]    C_PC_INC  = PC_W'(PC_INC);
  localparam logic [CAUSE_W-1:0] C_ADEL    = CAUSE_W'(ADEL_CAUSE);
  localparam logic [CNT_W-1:0]   C_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    epc_q, epc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               exl_q, exl_d;
  logic               flush_q, flush_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PC_W-1:0]    pc_seq;
  logic               take_exc;
  logic [CAUSE_W-1:0] exc_code;
  logic               target_aligned;

  assign pc_seq         = pc_q + C_PC_INC;
  assign target_aligned = (PCU_redir_target[1:0] == 2'b00);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    exl_d    = exl_q;
    cnt_d    = cnt_q;
    flush_d  = 1'b0;
    take_exc = 1'b0;
    exc_code = PCU_exc_cause;

    if (PCU_ena) begin
      // Exceptions win in both states and ignore stall.
      if (PCU_exc_req) begin
        take_exc = 1'b1;
      end else if (state_q == ST_HALT) begin
        if (PCU_resume) begin
          pc_d    = pc_seq;
          state_d = ST_RUN;
        end
      end else if (PCU_stall) begin
        pc_d = pc_q;
      end else if (PCU_eret) begin
        pc_d    = epc_q;
        exl_d   = 1'b0;
        flush_d = 1'b1;
      end else if (PCU_halt_req) begin
        state_d = ST_HALT;
      end else if (PCU_redir_valid) begin
        if (target_aligned) begin
          pc_d    = PCU_redir_target;
          flush_d = 1'b1;
        end else begin
          take_exc = 1'b1;
          exc_code = C_ADEL;
        end
      end else begin
        pc_d = pc_seq;
      end

      // A nested exception still vectors but keeps the original EPC/cause.
      if (take_exc) begin
        pc_d    = EXC_VEC;
        state_d = ST_RUN;
        flush_d = 1'b1;
        if (!exl_q) begin
          epc_d   = pc_q;
          cause_d = exc_code;
          exl_d   = 1'b1;
        end
      end

      if (pc_d != pc_q) begin
        cnt_d = cnt_q + C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge PCU_clk or negedge PCU_rst_n) begin
    if (!PCU_rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      cause_q <= '0;
      exl_q   <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCU_pc_out     = pc_q;
  assign PCU_epc        = epc_q;
  assign PCU_cause      = cause_q;
  assign PCU_exl        = exl_q;
  assign PCU_flush      = flush_q;
  assign PCU_halted     = (state_q == ST_HALT);
  assign PCU_retire_cnt = cnt_q;

endmodule

`default_nettype wire

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the CPU front end. Generalises the plain PC register.
- Holds the fetch PC and selects the next PC from four sources: sequential increment, branch/jump redirect, exception vector, and ERET return.
- Adds stall hold, a HALT state for break, EPC/cause capture with an EXL flag, misaligned-target trapping, a one-cycle flush pulse and a retired-fetch counter.
- Sits between the decode/branch logic and instruction memory.

Parameters:
- PC_W, 32, PC width in bits.
- RESET_VEC, 32'h00400000, PC value loaded on reset.
- EXC_VEC, 32'h00400004, exception handler entry address.
- PC_INC, 4, sequential increment.
- CAUSE_W, 5, exception cause code width.
- ADEL_CAUSE, 4, cause code written for a misaligned redirect.
- CNT_W, 16, retired-fetch counter width.

Ports:
- PCU_clk, in, 1, clock; all state updates on the rising edge.
- PCU_rst_n, in, 1, asynchronous active-low reset.
- PCU_ena, in, 1, global enable; 0 freezes all state.
- PCU_stall, in, 1, pipeline stall request.
- PCU_redir_valid, in, 1, branch/jump taken this cycle.
- PCU_redir_target, in, PC_W, redirect address.
- PCU_exc_req, in, 1, synchronous exception request.
- PCU_exc_cause, in, CAUSE_W, cause code for PCU_exc_req.
- PCU_eret, in, 1, return from exception.
- PCU_halt_req, in, 1, break instruction; enter HALT.
- PCU_resume, in, 1, leave HALT.
- PCU_pc_out, out, PC_W, current fetch PC (registered).
- PCU_epc, out, PC_W, exception PC.
- PCU_cause, out, CAUSE_W, last captured cause.
- PCU_exl, out, 1, exception level flag.
- PCU_flush, out, 1, one-cycle pulse after any non-sequential PC change.
- PCU_halted, out, 1, high while in HALT.
- PCU_retire_cnt, out, CNT_W, count of PC advances.

Behaviour:
- Reset: asserting PCU_rst_n low asynchronously forces:
  - PCU_pc_out = RESET_VEC.
  - PCU_epc = 0, PCU_cause = 0, PCU_exl = 0, PCU_flush = 0, PCU_retire_cnt = 0.
  - State = RUN, PCU_halted = 0.
  - Deassertion takes effect at the next rising edge. Reset mid-operation discards all pending state.
- Outputs are always driven; there is no tri-state.
- PCU_ena = 0: no register changes, PCU_flush = 0, inputs ignored.
- States: RUN and HALT. PCU_halted = (state == HALT).
- RUN priority per edge (highest first):
  1. PCU_exc_req:
     - PC <= EXC_VEC.
     - If PCU_exl = 0: EPC <= PC, cause <= PCU_exc_cause, EXL <= 1.
     - If PCU_exl = 1: EPC and cause unchanged (nested exception); PC still vectors.
     - Taken even if PCU_stall = 1.
  2. PCU_stall: PC holds. ERET, redirect, halt and sequential advance are all ignored.
  3. PCU_eret: PC <= EPC, EXL <= 0.
  4. PCU_halt_req: PC holds, state <= HALT.
  5. PCU_redir_valid:
     - If target[1:0] == 0: PC <= target.
     - Otherwise trap: PC <= EXC_VEC; EPC/cause/EXL update as in item 1 with cause = ADEL_CAUSE.
  6. Default: PC <= PC + PC_INC, modulo 2^PC_W (wraps, e.g. 32'hFFFFFFFC -> 0).
- HALT:
  - PC holds.
  - PCU_exc_req behaves as in RUN and returns state to RUN.
  - Otherwise PCU_resume: PC <= PC + PC_INC, state <= RUN.
  - All other inputs ignored.
- PCU_flush: registered; high for exactly the one cycle following an edge that applied an exception, trap, ERET or redirect. Low otherwise, including stall, sequential advance and HALT entry.
- PCU_retire_cnt: +1 on every edge where PC changes by any path while PCU_ena = 1. Wraps 2^CNT_W-1 -> 0.
- Latency: every PC change is visible on PCU_pc_out one cycle after the sampling edge.

Test Plan:
- Reset then 3 free-running cycles -> PCU_pc_out = 0x00400000, 0x00400004, 0x00400008, 0x0040000C; retire_cnt = 3; flush stays 0.
- At PC = 0x00400010: redirect to 0x00400100 with stall = 1 for 2 cycles, then stall = 0 -> PC holds 0x00400010 for 2 cycles, then 0x00400100; flush pulses 1 cycle.
- At PC = 0x00400020: exc_req with cause 8 -> PC = 0x00400004, EPC = 0x00400020, cause = 8, exl = 1. Second exc with cause 12 -> EPC/cause unchanged. eret -> PC = 0x00400020, exl = 0.
- Redirect to 0x00400102 -> PC = 0x00400004, cause = 4, EPC = PC at the time of the redirect.
- halt_req at PC = 0x00400030 -> halted = 1, PC frozen 5 cycles, redirect ignored. resume -> PC = 0x00400034, halted = 0.
- Drop PCU_rst_n mid-cycle while PC = 0x00400200 and exl = 1 -> immediately PC = 0x00400000, exl = 0, retire_cnt = 0, without waiting for a clock edge. With ena = 0, PC holds.
